// File: rtl/id_ex_pipe_if.sv
// ID/EX stage bundle: decoded instruction from decode, the registered copy
// presented to execute, the pipeline control inputs and the hazard/bubble status.
interface id_ex_pipe_if #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_data1;
  logic [XLEN-1:0]   in_data2;
  logic [XLEN-1:0]   in_imm;
  logic [RA_W-1:0]   in_rs1;
  logic [RA_W-1:0]   in_rs2;
  logic [RA_W-1:0]   in_rd;
  logic [CTRL_W-1:0] in_control;
  logic              ex_stall;
  logic              flush;

  logic              hazard_stall;
  logic              out_valid;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_data1;
  logic [XLEN-1:0]   out_data2;
  logic [XLEN-1:0]   out_imm;
  logic [RA_W-1:0]   out_rs1;
  logic [RA_W-1:0]   out_rs2;
  logic [RA_W-1:0]   out_rd;
  logic [CTRL_W-1:0] out_control;
  logic              out_memtoreg;
  logic              out_branch;
  logic              out_memwrite;
  logic              out_memread;
  logic              out_alusrc;
  logic              out_regwrite;
  logic [3:0]        out_alu_control;
  logic [CNT_W-1:0]  bubble_count;

  // Decode/pipeline-control side: drives the instruction, observes the stage.
  modport master (
    output in_valid, in_pc, in_data1, in_data2, in_imm, in_rs1, in_rs2, in_rd,
           in_control, ex_stall, flush,
    input  hazard_stall, out_valid, out_pc, out_data1, out_data2, out_imm,
           out_rs1, out_rs2, out_rd, out_control, out_memtoreg, out_branch,
           out_memwrite, out_memread, out_alusrc, out_regwrite, out_alu_control,
           bubble_count
  );

  // Pipeline register side.
  modport slave (
    input  in_valid, in_pc, in_data1, in_data2, in_imm, in_rs1, in_rs2, in_rd,
           in_control, ex_stall, flush,
    output hazard_stall, out_valid, out_pc, out_data1, out_data2, out_imm,
           out_rs1, out_rs2, out_rd, out_control, out_memtoreg, out_branch,
           out_memwrite, out_memread, out_alusrc, out_regwrite, out_alu_control,
           bubble_count
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with stall hold, flush bubbling and load-use
// hazard detection. A hazard freezes the front end for one cycle while a
// bubble (valid=0, control=0) is pushed into execute; hazard bubbles are
// counted by a saturating counter.
module id_ex_pipe #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_pipe_if.slave bus
);

  logic              hazard;
  logic              valid_q;
  logic [CTRL_W-1:0] control_q;
  logic [CNT_W-1:0]  count_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   data1_q;
  logic [XLEN-1:0]   data2_q;
  logic [XLEN-1:0]   imm_q;
  logic [RA_W-1:0]   rs1_q;
  logic [RA_W-1:0]   rs2_q;
  logic [RA_W-1:0]   rd_q;

  // Load-use check of the held instruction against the one in decode; rs2 is
  // compared unconditionally, trading an occasional spare bubble for simplicity.
  always_comb begin
    hazard = valid_q & control_q[3] & (rd_q != '0) & bus.in_valid &
             ((rd_q == bus.in_rs1) | (rd_q == bus.in_rs2));
  end

  // Payload fields load on every edge except a plain stall; their value in a
  // bubble is irrelevant because valid and control are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      data1_q <= '0;
      data2_q <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (bus.flush || !bus.ex_stall) begin
      pc_q    <= bus.in_pc;
      data1_q <= bus.in_data1;
      data2_q <= bus.in_data2;
      imm_q   <= bus.in_imm;
      rs1_q   <= bus.in_rs1;
      rs2_q   <= bus.in_rs2;
      rd_q    <= bus.in_rd;
    end
  end

  // Valid/control/bubble counter: flush beats stall, stall beats hazard, and
  // only hazard bubbles advance the counter, which sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      control_q <= '0;
      count_q   <= '0;
    end else if (bus.flush) begin
      valid_q   <= 1'b0;
      control_q <= '0;
    end else if (!bus.ex_stall) begin
      if (hazard) begin
        valid_q   <= 1'b0;
        control_q <= '0;
        if (count_q != '1) begin
          count_q <= count_q + CNT_W'(1);
        end
      end else begin
        valid_q   <= bus.in_valid;
        control_q <= bus.in_valid ? bus.in_control : '0;
      end
    end
  end

  assign bus.hazard_stall    = hazard & ~bus.flush;
  assign bus.out_valid       = valid_q;
  assign bus.out_pc          = pc_q;
  assign bus.out_data1       = data1_q;
  assign bus.out_data2       = data2_q;
  assign bus.out_imm         = imm_q;
  assign bus.out_rs1         = rs1_q;
  assign bus.out_rs2         = rs2_q;
  assign bus.out_rd          = rd_q;
  assign bus.out_control     = control_q;
  assign bus.out_memtoreg    = control_q[0];
  assign bus.out_branch      = control_q[1];
  assign bus.out_memwrite    = control_q[2];
  assign bus.out_memread     = control_q[3];
  assign bus.out_alusrc      = control_q[4];
  assign bus.out_alu_control = control_q[8:5];
  assign bus.out_regwrite    = control_q[9];
  assign bus.bubble_count    = count_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Testbench for id_ex_pipe: two instances (16-bit and 2-bit bubble counter)
// share one stimulus stream and are compared every cycle against a
// behavioural model, with directed literal checks along the way.
module tb_id_ex_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0, in_data1 = '0, in_data2 = '0, in_imm = '0;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [9:0]  in_control = '0;
  logic        ex_stall = 1'b0;
  logic        flush = 1'b0;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  id_ex_pipe_if #(.XLEN(32), .RA_W(5), .CTRL_W(10), .CNT_W(16)) bus_a ();
  id_ex_pipe_if #(.XLEN(32), .RA_W(5), .CTRL_W(10), .CNT_W(2))  bus_b ();

  assign bus_a.in_valid = in_valid;   assign bus_b.in_valid = in_valid;
  assign bus_a.in_pc = in_pc;         assign bus_b.in_pc = in_pc;
  assign bus_a.in_data1 = in_data1;   assign bus_b.in_data1 = in_data1;
  assign bus_a.in_data2 = in_data2;   assign bus_b.in_data2 = in_data2;
  assign bus_a.in_imm = in_imm;       assign bus_b.in_imm = in_imm;
  assign bus_a.in_rs1 = in_rs1;       assign bus_b.in_rs1 = in_rs1;
  assign bus_a.in_rs2 = in_rs2;       assign bus_b.in_rs2 = in_rs2;
  assign bus_a.in_rd = in_rd;         assign bus_b.in_rd = in_rd;
  assign bus_a.in_control = in_control; assign bus_b.in_control = in_control;
  assign bus_a.ex_stall = ex_stall;   assign bus_b.ex_stall = ex_stall;
  assign bus_a.flush = flush;         assign bus_b.flush = flush;

  id_ex_pipe #(.XLEN(32), .RA_W(5), .CTRL_W(10), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  id_ex_pipe #(.XLEN(32), .RA_W(5), .CTRL_W(10), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  // 10-time-unit clock.
  always #5 clk = ~clk;

  // Behavioural model of what the stage holds.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0, m_data1 = '0, m_data2 = '0, m_imm = '0;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [9:0]  m_ctrl = '0;
  int          m_count = 0;

  // A held valid load to a nonzero register that decode's instruction names.
  function automatic logic model_hazard();
    return m_valid && m_ctrl[3] && (m_rd != 5'd0) && in_valid &&
           ((m_rd == in_rs1) || (m_rd == in_rs2));
  endfunction

  function automatic int sat(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  // Model update: what the stage must hold after each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_ctrl <= '0; m_count <= 0;
      m_pc <= '0; m_data1 <= '0; m_data2 <= '0; m_imm <= '0;
      m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0;
    end else if (flush || !ex_stall) begin
      m_pc <= in_pc; m_data1 <= in_data1; m_data2 <= in_data2; m_imm <= in_imm;
      m_rs1 <= in_rs1; m_rs2 <= in_rs2; m_rd <= in_rd;
      if (flush) begin
        m_valid <= 1'b0;
        m_ctrl  <= '0;
      end else if (model_hazard()) begin
        m_valid <= 1'b0;
        m_ctrl  <= '0;
        m_count <= m_count + 1;
      end else begin
        m_valid <= in_valid;
        m_ctrl  <= in_valid ? in_control : 10'd0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("a.valid", 64'(bus_a.out_valid), 64'(m_valid));
      checkOutput("a.control", 64'(bus_a.out_control), 64'(m_ctrl));
      checkOutput("a.memtoreg", 64'(bus_a.out_memtoreg), 64'(m_ctrl[0]));
      checkOutput("a.branch", 64'(bus_a.out_branch), 64'(m_ctrl[1]));
      checkOutput("a.memwrite", 64'(bus_a.out_memwrite), 64'(m_ctrl[2]));
      checkOutput("a.memread", 64'(bus_a.out_memread), 64'(m_ctrl[3]));
      checkOutput("a.alusrc", 64'(bus_a.out_alusrc), 64'(m_ctrl[4]));
      checkOutput("a.alu_control", 64'(bus_a.out_alu_control), 64'(m_ctrl[8:5]));
      checkOutput("a.regwrite", 64'(bus_a.out_regwrite), 64'(m_ctrl[9]));
      checkOutput("a.bubble_count", 64'(bus_a.bubble_count), 64'(sat(m_count, 65535)));
      checkOutput("a.hazard_stall", 64'(bus_a.hazard_stall), 64'(model_hazard() && !flush));
      checkOutput("b.valid", 64'(bus_b.out_valid), 64'(m_valid));
      checkOutput("b.control", 64'(bus_b.out_control), 64'(m_ctrl));
      checkOutput("b.bubble_count", 64'(bus_b.bubble_count), 64'(sat(m_count, 3)));
      checkOutput("b.hazard_stall", 64'(bus_b.hazard_stall), 64'(model_hazard() && !flush));
      if (m_valid) begin
        checkOutput("a.pc", 64'(bus_a.out_pc), 64'(m_pc));
        checkOutput("a.data1", 64'(bus_a.out_data1), 64'(m_data1));
        checkOutput("a.data2", 64'(bus_a.out_data2), 64'(m_data2));
        checkOutput("a.imm", 64'(bus_a.out_imm), 64'(m_imm));
        checkOutput("a.rs1", 64'(bus_a.out_rs1), 64'(m_rs1));
        checkOutput("a.rs2", 64'(bus_a.out_rs2), 64'(m_rs2));
        checkOutput("a.rd", 64'(bus_a.out_rd), 64'(m_rd));
        checkOutput("b.data1", 64'(bus_b.out_data1), 64'(m_data1));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [9:0] ctrl,
                               input logic stall, input logic fl);
    in_valid = v; in_pc = pc; in_data1 = d1; in_data2 = d2;
    in_imm = d1 ^ d2; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_control = ctrl; ex_stall = stall; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    step(); step();
    rst = 1'b0;
    check_en = 1'b1;

    // Pass-through of an all-ones control word.
    applyStimulus(1, 32'h100, 32'h12345678, 32'hCAFEF00D, 5'd1, 5'd2, 5'd7, 10'h3FF, 0, 0);
    step();
    checkOutput("pt.valid", 64'(bus_a.out_valid), 64'd1);
    checkOutput("pt.data1", 64'(bus_a.out_data1), 64'h12345678);
    checkOutput("pt.rd", 64'(bus_a.out_rd), 64'd7);
    checkOutput("pt.alu_control", 64'(bus_a.out_alu_control), 64'hF);
    checkOutput("pt.decoded", 64'({bus_a.out_memtoreg, bus_a.out_branch, bus_a.out_memwrite,
                bus_a.out_memread, bus_a.out_alusrc, bus_a.out_regwrite}), 64'h3F);

    // Load-use: load to x5 then a consumer reading x5 through rs2.
    applyStimulus(1, 32'h104, 32'h1, 32'h2, 5'd1, 5'd2, 5'd5, 10'h209, 0, 0);
    step();
    applyStimulus(1, 32'h108, 32'h3, 32'h4, 5'd3, 5'd5, 5'd6, 10'h200, 0, 0);
    #1 checkOutput("lu.hazard_stall", 64'(bus_a.hazard_stall), 64'd1);
    step();
    checkOutput("lu.bubble_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("lu.bubble_control", 64'(bus_a.out_control), 64'd0);
    checkOutput("lu.bubble_count", 64'(bus_a.bubble_count), 64'd1);
    checkOutput("lu.stall_cleared", 64'(bus_a.hazard_stall), 64'd0);
    step();
    checkOutput("lu.consumer_rd", 64'(bus_a.out_rd), 64'd6);
    checkOutput("lu.consumer_valid", 64'(bus_a.out_valid), 64'd1);

    // No-hazard cases: load to x0, non-load producer, invalid decode slot.
    applyStimulus(1, 32'h10C, 32'h5, 32'h6, 5'd1, 5'd2, 5'd0, 10'h008, 0, 0);
    step();
    applyStimulus(1, 32'h110, 32'h7, 32'h8, 5'd0, 5'd0, 5'd5, 10'h200, 0, 0);
    #1 checkOutput("nh.rd0", 64'(bus_a.hazard_stall), 64'd0);
    step();
    applyStimulus(1, 32'h114, 32'h9, 32'hA, 5'd5, 5'd1, 5'd8, 10'h010, 0, 0);
    #1 checkOutput("nh.nonload", 64'(bus_a.hazard_stall), 64'd0);
    step();
    applyStimulus(1, 32'h118, 32'hB, 32'hC, 5'd1, 5'd2, 5'd5, 10'h209, 0, 0);
    step();
    applyStimulus(0, 32'h11C, 32'hD, 32'hE, 5'd5, 5'd5, 5'd3, 10'h3FF, 0, 0);
    #1 checkOutput("nh.invalid", 64'(bus_a.hazard_stall), 64'd0);
    step();
    checkOutput("nh.invalid_control", 64'(bus_a.out_control), 64'd0);

    // Stall hold with changing inputs.
    applyStimulus(1, 32'h200, 32'hAAAA5555, 32'h0F0F0F0F, 5'd3, 5'd4, 5'd10, 10'h155, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h300 + 32'(i), 32'h1000 + 32'(i), 32'h2000, 5'd6, 5'd7,
                    5'd11, 10'h0A2, 1, 0);
      step();
      checkOutput("st.pc", 64'(bus_a.out_pc), 64'h200);
      checkOutput("st.data1", 64'(bus_a.out_data1), 64'hAAAA5555);
      checkOutput("st.control", 64'(bus_a.out_control), 64'h155);
      checkOutput("st.count", 64'(bus_a.bubble_count), 64'd1);
    end
    applyStimulus(1, 32'h204, 32'h11, 32'h22, 5'd1, 5'd2, 5'd9, 10'h209, 0, 0);
    step();
    applyStimulus(1, 32'h208, 32'h33, 32'h44, 5'd9, 5'd2, 5'd11, 10'h200, 1, 0);
    #1 checkOutput("sh.hazard_stall", 64'(bus_a.hazard_stall), 64'd1);
    step();
    checkOutput("sh.held_rd", 64'(bus_a.out_rd), 64'd9);
    checkOutput("sh.count", 64'(bus_a.bubble_count), 64'd1);
    ex_stall = 1'b0;
    step();
    checkOutput("sh.bubble_count", 64'(bus_a.bubble_count), 64'd2);
    step();

    // Flush with hazard, then flush with stall.
    applyStimulus(1, 32'h20C, 32'h55, 32'h66, 5'd1, 5'd2, 5'd4, 10'h209, 0, 0);
    step();
    applyStimulus(1, 32'h210, 32'h77, 32'h88, 5'd1, 5'd4, 5'd12, 10'h200, 0, 1);
    #1 checkOutput("fh.hazard_stall", 64'(bus_a.hazard_stall), 64'd0);
    step();
    checkOutput("fh.valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("fh.count", 64'(bus_a.bubble_count), 64'd2);
    applyStimulus(1, 32'h214, 32'h99, 32'hAA, 5'd1, 5'd2, 5'd12, 10'h200, 0, 0);
    step();
    applyStimulus(1, 32'h218, 32'hBB, 32'hCC, 5'd1, 5'd2, 5'd13, 10'h200, 1, 1);
    step();
    checkOutput("fs.valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("fs.control", 64'(bus_a.out_control), 64'd0);

    // Mid-cycle asynchronous reset while holding a real instruction.
    applyStimulus(1, 32'h21C, 32'hDD, 32'hEE, 5'd1, 5'd2, 5'd5, 10'h209, 0, 0);
    step();
    applyStimulus(1, 32'h220, 32'h1, 32'h2, 5'd5, 5'd5, 5'd5, 10'h209, 0, 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst.valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("rst.pc", 64'(bus_a.out_pc), 64'd0);
    checkOutput("rst.control", 64'(bus_a.out_control), 64'd0);
    checkOutput("rst.count", 64'(bus_a.bubble_count), 64'd0);
    checkOutput("rst.hazard_stall", 64'(bus_a.hazard_stall), 64'd0);
    step();
    rst = 1'b0;

    // Saturation: a self-dependent load chain gives one bubble per pair of edges.
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("sat.b_count", 64'(bus_b.bubble_count), 64'(sat_exp[i]));
      checkOutput("sat.a_count", 64'(bus_a.bubble_count), 64'(i + 1));
      step();
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline stage register with stall, flush and load-use hazard bubble insertion. It sits between decode (register file read, immediate generation, main control) and execute. It captures the decoded operands, register addresses and the control bus each cycle. It also detects the load-use hazard against the instruction it currently holds, freezes the front end and injects a one-cycle bubble.

## Interface
Parameters:
- XLEN, 32, datapath width of operands, immediate and PC
- RA_W, 5, register-address width
- CTRL_W, 10, control bus width; minimum 10, bits above 9 are carried through undecoded
- CNT_W, 16, width of the saturating hazard-bubble counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode stage holds a real instruction
- in_pc, in_data1, in_data2, in_imm  in  XLEN  PC, rs1 value, rs2 value, sign-extended immediate
- in_rs1, in_rs2, in_rd  in  RA_W  source and destination register numbers
- in_control  in  CTRL_W  control bus: [0] memtoreg, [1] branch, [2] memwrite, [3] memread, [4] alusrc, [8:5] alu_control, [9] regwrite
- ex_stall  in  1  execute/memory cannot accept; hold contents
- flush  in  1  branch/jump redirect; discard the incoming instruction
- hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle
- out_valid  out  1  stage holds a real instruction
- out_pc, out_data1, out_data2, out_imm  out  XLEN  registered copies
- out_rs1, out_rs2, out_rd  out  RA_W  registered copies
- out_control  out  CTRL_W  registered control bus
- out_memtoreg, out_branch, out_memwrite, out_memread, out_alusrc, out_regwrite  out  1  decoded from out_control
- out_alu_control  out  4  out_control[8:5]
- bubble_count  out  CNT_W  number of hazard bubbles inserted

## Operation
- The hazard condition is: out_valid & out_memread & (out_rd != 0) & in_valid & ((out_rd == in_rs1) | (out_rd == in_rs2)). The check is conservative: rs2 is compared even for instructions that do not read it.
- hazard_stall = hazard & ~flush. It is purely combinational and has no dependence on ex_stall.
- Per-edge update, with this priority:
  1. rst: all registered outputs go to 0, including bubble_count.
  2. flush: load a bubble. out_valid=0 and out_control=0. All other fields take the input values, which are don't-care.
  3. ex_stall: every register holds, including out_valid and bubble_count.
  4. hazard: load a bubble as in step 2. bubble_count increments.
  5. otherwise: load all inputs. out_valid=in_valid, and out_control=in_control when in_valid, else 0.
- A bubble always presents out_control=0, so no regwrite, memwrite, memread or branch reaches execute.
- bubble_count saturates at 2^CNT_W-1 and never wraps. It counts only hazard bubbles, not flushes or reset.
- Decoded outputs are continuous slices of out_control. They hold no separate state.

## Timing
- Latency is 1 cycle from input to output when there is no stall, flush or hazard.
- A load-use pair costs exactly 1 bubble:
  - Cycle N: the load is in the stage and the consumer is in decode, so hazard_stall=1.
  - Edge N+1: a bubble is loaded. Upstream holds the consumer.
  - Cycle N+1: out_valid=0, so hazard_stall=0.
  - Edge N+2: the consumer is loaded.
- If ex_stall and hazard are both active, the register holds and the counter does not increment. hazard_stall stays 1, which is harmless because upstream is also stalled.
- If flush and hazard are both active, flush wins, hazard_stall=0 and the counter does not increment.
- If flush and ex_stall are both active, flush wins and the stage is bubbled.
- Asynchronous rst takes effect immediately, even mid-stall or mid-bubble. hazard_stall falls to 0 as soon as out_valid clears.
- rd=0 never creates a hazard. A load into x0 followed by a consumer of x0 proceeds with no bubble.

## Test plan
- Reset/pass-through:
  - Assert rst mid-cycle: all outputs are 0 immediately.
  - After release, drive in_valid=1, data1=0x12345678, rd=7, control=0x3FF: outputs match one edge later, out_alu_control=0xF, and every decoded bit is 1.
- Load-use:
  - Hold a load in the stage (memread=1, rd=5) with in_rs2=5: hazard_stall=1, the next edge gives out_valid=0 and out_control=0, and bubble_count=1.
  - Holding the input for one more edge loads the consumer, and hazard_stall=0.
- No-hazard cases:
  - A load to rd=0 with in_rs1=0 gives no stall.
  - A non-load with rd=5 and in_rs1=5 gives no stall.
  - in_valid=0 gives no stall.
- Stall hold: assert ex_stall for 3 cycles with changing inputs: outputs and bubble_count stay unchanged. When ex_stall coincides with a hazard, the count is unchanged.
- Flush priority:
  - flush together with a hazard: a bubble is loaded, hazard_stall=0, and the count is unchanged.
  - flush together with ex_stall: a bubble is loaded.
- Saturation: with CNT_W=2, force 5 hazard bubbles: bubble_count reads 1, 2, 3, 3, 3.
